// File: rtl/int_pkg.sv
// int_pkg: shared types and constants for the interrupt sequencer slice
package int_pkg;
  typedef enum logic [1:0] {IDLE, ENTRY, EXIT} seq_state_e;
  localparam logic [2:0] LVL0 = 3'b001;
  localparam logic [2:0] LVL1 = 3'b010;
  localparam logic [2:0] LVL2 = 3'b100;
  localparam logic [31:0] VEC0_DEF = 32'h0000_0100;
  localparam logic [31:0] VEC1_DEF = 32'h0000_0200;
  localparam logic [31:0] VEC2_DEF = 32'h0000_0300;
endpackage

// File: rtl/epc_stack.sv
// epc_stack: LIFO of return addresses, pointer doubles as occupancy and saturates at both ends
module epc_stack #(
  parameter int ADDR_W = 32,
  parameter int DEPTH = 3,
  parameter int PTR_W = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [ADDR_W-1:0] din_i,
  output logic [ADDR_W-1:0] dout_o,
  output logic [PTR_W-1:0]  depth_o,
  output logic              full_o,
  output logic              empty_o
);
  logic [ADDR_W-1:0] stack_q [DEPTH];
  logic [PTR_W-1:0]  ptr_q;
  assign depth_o = ptr_q;
  assign full_o  = ptr_q == PTR_W'(DEPTH);
  assign empty_o = ptr_q == '0;
  assign dout_o  = empty_o ? '0 : stack_q[ptr_q - 1'b1];
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
      ptr_q <= '0;
    end else if (push_i && !full_o) begin
      stack_q[ptr_q] <= din_i;
      ptr_q <= ptr_q + 1'b1;
    end else if (pop_i && !empty_o) begin
      ptr_q <= ptr_q - 1'b1;
    end
  end
endmodule

// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer: takes interrupts at instruction boundaries, nests EPCs, redirects fetch, returns on eret
module interrupt_sequencer
  import int_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] VEC0 = ADDR_W'(VEC0_DEF),
  parameter logic [ADDR_W-1:0] VEC1 = ADDR_W'(VEC1_DEF),
  parameter logic [ADDR_W-1:0] VEC2 = ADDR_W'(VEC2_DEF),
  parameter int DEPTH = 3,
  parameter int PTR_W = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              interrupted,
  input  logic [2:0]        interruptOut,
  input  logic              instrBoundary,
  input  logic [ADDR_W-1:0] pcNext,
  input  logic              eret,
  output logic              redirect,
  output logic [ADDR_W-1:0] redirectPc,
  output logic              interruptEnd,
  output logic [PTR_W-1:0]  depth,
  output logic              overflow,
  output logic              underflow
);
  seq_state_e        state_q;
  logic              pend_q, redirect_q, int_end_q, ovf_q, unf_q;
  logic [2:0]        pend_lvl_q;
  logic [ADDR_W-1:0] redirect_pc_q, epc;
  logic              full, empty;
  function automatic logic [ADDR_W-1:0] vec_sel(input logic [2:0] l);
    return |(l & LVL2) ? VEC2 : |(l & LVL1) ? VEC1 : VEC0;
  endfunction
  // Boundaries during ENTRY/EXIT belong to the flushed pipeline and are ignored
  wire take_eret = state_q == IDLE && instrBoundary && eret;
  wire take_irq  = state_q == IDLE && instrBoundary && !eret && pend_q;
  wire push      = take_irq && !full;
  wire pop       = take_eret && !empty;
  epc_stack #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_stack (
    .clock(clock), .reset(reset), .push_i(push), .pop_i(pop), .din_i(pcNext),
    .dout_o(epc), .depth_o(depth), .full_o(full), .empty_o(empty)
  );
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= IDLE;
      pend_q        <= 1'b0;
      pend_lvl_q    <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      int_end_q     <= 1'b0;
      ovf_q         <= 1'b0;
      unf_q         <= 1'b0;
    end else begin
      state_q    <= pop ? EXIT : push ? ENTRY : IDLE;
      redirect_q <= pop || push;
      int_end_q  <= pop;
      if (pop) redirect_pc_q <= epc;
      else if (push) redirect_pc_q <= vec_sel(pend_lvl_q);
      if (take_eret && empty) unf_q <= 1'b1;
      if (take_irq && full) ovf_q <= 1'b1;
      if (take_irq) pend_q <= 1'b0;
      // A pulse on the same edge as a take survives: it is the next level to serve
      if (interrupted && |interruptOut) begin
        pend_q     <= 1'b1;
        pend_lvl_q <= interruptOut;
      end
    end
  end
  assign redirect     = redirect_q;
  assign redirectPc   = redirect_pc_q;
  assign interruptEnd = int_end_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;
endmodule

// File: tb/tb_interrupt_sequencer.sv
// tb_interrupt_sequencer: random and directed stimulus checked each cycle against a queue-based model
module tb_interrupt_sequencer;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        interrupted = 1'b0;
  logic [2:0]  interruptOut = '0;
  logic        instrBoundary = 1'b0;
  logic [31:0] pcNext = '0;
  logic        eret = 1'b0;
  logic        redirect, interruptEnd, overflow, underflow;
  logic [31:0] redirectPc;
  logic [1:0]  depth;
  int checks = 0;
  int errors = 0;
  logic [31:0] m_stack[$];
  logic        m_pend = 0, m_red = 0, m_end = 0, m_ovf = 0, m_unf = 0;
  logic [2:0]  m_lvl = 0;
  logic [31:0] m_pc = 0;

  interrupt_sequencer dut (
    .clock(clock), .reset(reset), .interrupted(interrupted), .interruptOut(interruptOut),
    .instrBoundary(instrBoundary), .pcNext(pcNext), .eret(eret), .redirect(redirect),
    .redirectPc(redirectPc), .interruptEnd(interruptEnd), .depth(depth),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] vec_of(input logic [2:0] l);
    if (l[2]) return 32'h300;
    if (l[1]) return 32'h200;
    return 32'h100;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic n_red, n_end;
    if (!reset) begin
      m_stack.delete();
      m_pend = 0; m_lvl = 0; m_red = 0; m_end = 0; m_pc = 0; m_ovf = 0; m_unf = 0;
      return;
    end
    n_red = 0; n_end = 0;
    if (!m_red && instrBoundary) begin
      if (eret) begin
        if (m_stack.size() > 0) begin m_pc = m_stack.pop_back(); n_red = 1; n_end = 1; end
        else m_unf = 1;
      end else if (m_pend) begin
        if (m_stack.size() < 3) begin m_stack.push_back(pcNext); m_pc = vec_of(m_lvl); n_red = 1; end
        else m_ovf = 1;
        m_pend = 0;
      end
    end
    if (interrupted && interruptOut != 0) begin m_pend = 1; m_lvl = interruptOut; end
    m_red = n_red; m_end = n_end;
  endtask

  task automatic step(input logic rn, input logic intr, input logic [2:0] lvl,
                      input logic bnd, input logic [31:0] pc, input logic er);
    reset = rn; interrupted = intr; interruptOut = lvl;
    instrBoundary = bnd; pcNext = pc; eret = er;
    @(posedge clock);
    model_edge();
    @(negedge clock);
    chk("redirect", 32'(redirect), 32'(m_red));
    chk("redirectPc", redirectPc, m_pc);
    chk("interruptEnd", 32'(interruptEnd), 32'(m_end));
    chk("depth", 32'(depth), 32'(m_stack.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
  endtask

  task automatic idle(); step(1, 0, 0, 0, 0, 0); endtask
  task automatic pulse(input logic [2:0] l); step(1, 1, l, 0, 0, 0); endtask
  task automatic bound(input logic [31:0] pc); step(1, 0, 0, 1, pc, 0); endtask
  task automatic do_eret(); step(1, 0, 0, 1, 32'h999, 1); endtask
  task automatic do_reset(); step(0, 0, 0, 0, 0, 0); step(0, 0, 0, 0, 0, 0); endtask

  initial begin
    do_reset();
    chk("lit_reset_red", 32'(redirect), 0);
    chk("lit_reset_depth", 32'(depth), 0);
    // single entry/return
    pulse(3'b010); bound(32'h40);
    chk("lit_entry_red", 32'(redirect), 1);
    chk("lit_entry_pc", redirectPc, 32'h200);
    chk("lit_entry_depth", 32'(depth), 1);
    idle();
    chk("lit_entry_once", 32'(redirect), 0);
    do_eret();
    chk("lit_exit_pc", redirectPc, 32'h40);
    chk("lit_exit_end", 32'(interruptEnd), 1);
    chk("lit_exit_depth", 32'(depth), 0);
    idle();
    chk("lit_end_once", 32'(interruptEnd), 0);
    // nesting
    pulse(3'b001); bound(32'h10);
    chk("lit_nest1_pc", redirectPc, 32'h100);
    idle(); pulse(3'b100); bound(32'h104);
    chk("lit_nest2_pc", redirectPc, 32'h300);
    chk("lit_nest2_depth", 32'(depth), 2);
    idle(); do_eret();
    chk("lit_ret1_pc", redirectPc, 32'h104);
    idle(); do_eret();
    chk("lit_ret2_pc", redirectPc, 32'h10);
    chk("lit_ret2_end", 32'(interruptEnd), 1);
    idle();
    // overflow
    for (int i = 0; i < 3; i++) begin pulse(3'b001 << i); bound(32'h1000 + i); idle(); end
    chk("lit_full_depth", 32'(depth), 3);
    pulse(3'b100); bound(32'h2000);
    chk("lit_ovf", 32'(overflow), 1);
    chk("lit_ovf_nored", 32'(redirect), 0);
    chk("lit_ovf_depth", 32'(depth), 3);
    // underflow
    do_reset(); do_eret();
    chk("lit_unf", 32'(underflow), 1);
    chk("lit_unf_nored", 32'(redirect), 0);
    chk("lit_unf_noend", 32'(interruptEnd), 0);
    // same-cycle eret and pend
    idle(); pulse(3'b001); bound(32'h50); idle();
    pulse(3'b010); do_eret();
    chk("lit_eret_prio_pc", redirectPc, 32'h50);
    idle(); bound(32'h54);
    chk("lit_pend_after_exit", redirectPc, 32'h200);
    chk("lit_pend_after_depth", 32'(depth), 1);
    // reset during ENTRY
    idle(); pulse(3'b100); bound(32'h60);
    chk("lit_pre_rst_red", 32'(redirect), 1);
    step(0, 1, 3'b001, 0, 0, 0);
    chk("lit_rst_red", 32'(redirect), 0);
    chk("lit_rst_depth", 32'(depth), 0);
    chk("lit_rst_pc", redirectPc, 0);
    idle(); bound(32'h70);
    chk("lit_rst_pend_clr", 32'(redirect), 0);
    // random traffic
    for (int n = 0; n < 3000; n++) begin
      logic b;
      b = ($urandom_range(0, 1) == 1);
      step($urandom_range(0, 99) != 0, $urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)),
           b, $urandom, b && $urandom_range(0, 2) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
- Downstream consumer of the priority interrupt controller's `interrupted` pulse and `interruptOut` one-hot level.
- Decides when the CPU actually takes an interrupt (instruction boundary only).
- Keeps a nested EPC stack, redirects fetch to the level vector, and on `eret` pops the EPC and returns the `interruptEnd` pulse to the controller.
- Sits between the controller and the PC/fetch stage.

Parameters:
- ADDR_W, 32, PC/address width.
- VEC0, 32'h0000_0100, handler address for interruptOut==3'b001.
- VEC1, 32'h0000_0200, handler address for interruptOut==3'b010.
- VEC2, 32'h0000_0300, handler address for interruptOut==3'b100.
- DEPTH, 3, EPC stack entries (one per level).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low.
- interrupted  in  1  one-cycle request pulse from the controller.
- interruptOut  in  3  one-hot active level from the controller.
- instrBoundary  in  1  an instruction retires this cycle; pcNext valid.
- pcNext  in  ADDR_W  address of the next sequential instruction (return address).
- eret  in  1  retiring instruction is ERET; valid only with instrBoundary.
- redirect  out  1  fetch must load redirectPc (one-cycle pulse).
- redirectPc  out  ADDR_W  vector or popped EPC.
- interruptEnd  out  1  one-cycle pulse to the controller.
- depth  out  2  current stack occupancy.
- overflow  out  1  sticky: request dropped because the stack was full.
- underflow  out  1  sticky: eret with empty stack.

Behaviour:
- Reset:
  - Sampled at posedge when reset==0.
  - All outputs become 0: redirect, redirectPc, interruptEnd, depth, overflow, underflow.
  - Stack contents are cleared, pend=0, state=IDLE.
  - Reset mid-entry or mid-exit aborts it; no redirect or interruptEnd is emitted afterwards.
- Pending latch:
  - At a posedge with interrupted==1 and interruptOut!=0: pend<=1 and pendLvl<=interruptOut.
  - A later pulse while pend==1 overwrites pendLvl (the controller always presents the highest active level).
  - interruptOut==0 with interrupted==1 is ignored.
- FSM states: IDLE, ENTRY, EXIT.
  - IDLE, instrBoundary && eret:
    - If depth>0: pop, go to EXIT. eret takes priority over pend, even in the same cycle.
    - If depth==0: set underflow, stay IDLE, no pulses.
  - IDLE, instrBoundary && !eret && pend:
    - If depth<DEPTH: push pcNext, pend<=0, latch vector(pendLvl), go to ENTRY.
    - If full: set overflow, pend<=0, stay IDLE.
  - IDLE, a pulse arriving in the same cycle as a boundary: not taken that cycle. It is latched into pend and taken at the next boundary.
  - ENTRY: redirect=1, redirectPc=vector, for exactly one cycle; then IDLE.
  - EXIT: redirect=1, redirectPc=popped EPC, interruptEnd=1, for exactly one cycle; then IDLE.
  - In ENTRY/EXIT, instrBoundary is ignored (the pipeline is flushing). interrupted is still latched into pend.
- Latency:
  - Boundary sampled at edge b → redirect high during cycle b+1.
  - A pend still set after EXIT is taken at the next boundary, pushing that boundary's pcNext (the return target). This gives back-to-back servicing with no lost level.
- Stack:
  - LIFO of DEPTH x ADDR_W with pointer = depth.
  - Push and pop never occur in the same cycle.
  - depth saturates at 0 and DEPTH; the pointer never wraps.
- Vector selection uses one-hot pendLvl. A non-one-hot value selects the highest set bit.
- Flags: overflow and underflow are cleared only by reset.

Decomposition:
- Shared package `int_pkg`:
  - sequencer state enum {IDLE, ENTRY, EXIT};
  - level one-hot constants LVL0/1/2;
  - default vector constants.
- One sub-module, `epc_stack`:
  - push, pop, din, dout, depth, full, empty;
  - parameterised by ADDR_W and DEPTH.

Test Plan:
- Single entry/return: interrupted, interruptOut=3'b010, then a boundary with pcNext=0x40 → redirect with 0x200 the next cycle, depth=1. Later, a boundary with eret → redirect with 0x40, interruptEnd=1 for exactly one cycle, depth=0.
- Nesting: level 001 taken (pcNext=0x10), then level 100 taken (pcNext=0x104) → redirects 0x100 then 0x300, depth=2. Two erets → 0x104 then 0x10, two interruptEnd pulses.
- Overflow: three levels taken (depth=3), then one more request plus a boundary → overflow=1, no redirect, depth stays 3.
- Underflow: eret boundary at depth 0 → underflow=1, redirect=0, interruptEnd=0.
- Same-cycle eret and pend: depth=1 with pend set for 010, boundary with eret and pcNext=X → EXIT to the popped EPC=E. The next boundary with pcNext=E+4 → ENTRY to 0x200, pushing E+4.
- Reset mid-ENTRY: reset=0 in the ENTRY cycle → redirect=0 and every output 0 on the next cycle; pend, depth and flags cleared.
